// File: rtl/spike_window_decoder.sv
// spike_window_decoder: counts output-neuron spikes over a fixed window, then posts the argmax class.
// Define SPIKE_DECODE_AUTORESTART_EN for back-to-back windows without start.
module spike_window_decoder #(
   parameter int NUM_OUT = 2,
   parameter int CNT_W = 8,
   parameter int WINDOW_CYCLES = 256,
   localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
   localparam int TMR_W = $clog2(WINDOW_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     start,
   input  logic [NUM_OUT-1:0]       spike_in,
   output logic                     busy,
   output logic                     done,
   output logic [IDX_W-1:0]         winner,
   output logic                     winner_valid,
   output logic                     tie,
   output logic [NUM_OUT*CNT_W-1:0] counts
);
   typedef enum logic [1:0] {IDLE, COUNT, DECIDE, DONE} state_t;
   state_t state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d, best_q, best_d, winner_q, winner_d;
   logic [CNT_W-1:0] max_q, max_d, cur;
   logic tie_run_q, tie_run_d, tie_q, tie_d, valid_q, valid_d, done_q, done_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q <= '0;
         cnt_q <= '0;
         idx_q <= '0;
         best_q <= '0;
         max_q <= '0;
         tie_run_q <= 1'b0;
         winner_q <= '0;
         tie_q <= 1'b0;
         valid_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q <= tmr_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         best_q <= best_d;
         max_q <= max_d;
         tie_run_q <= tie_run_d;
         winner_q <= winner_d;
         tie_q <= tie_d;
         valid_q <= valid_d;
         done_q <= done_d;
      end
   end
   always_comb begin
      state_d = state_q;
      tmr_d = tmr_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      best_d = best_q;
      max_d = max_q;
      tie_run_d = tie_run_q;
      winner_d = winner_q;
      tie_d = tie_q;
      valid_d = valid_q;
      done_d = 1'b0;
      cur = cnt_q[idx_q];
      case (state_q)
         IDLE: if (start) begin
            cnt_d = '0;
            tmr_d = '0;
            state_d = COUNT;
         end
         COUNT: begin
            idx_d = '0;
            if (en) begin
               for (int i = 0; i < NUM_OUT; i++)
                  if (spike_in[i] && cnt_q[i] != {CNT_W{1'b1}}) cnt_d[i] = cnt_q[i] + CNT_W'(1);
               tmr_d = tmr_q + TMR_W'(1);
               if (tmr_d == TMR_W'(WINDOW_CYCLES)) state_d = DECIDE;
            end
         end
         DECIDE: begin
            // strict-greater update keeps the lowest index on equal counts
            if (idx_q == '0) begin
               max_d = cur;
               best_d = '0;
               tie_run_d = 1'b0;
            end else if (cur > max_q) begin
               max_d = cur;
               best_d = idx_q;
               tie_run_d = 1'b0;
            end else if (cur == max_q) tie_run_d = 1'b1;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_OUT - 1)) state_d = DONE;
         end
         DONE: begin
            winner_d = best_q;
            tie_d = tie_run_q;
            valid_d = max_q != '0;
            done_d = 1'b1;
`ifdef SPIKE_DECODE_AUTORESTART_EN
            cnt_d = '0;
            tmr_d = '0;
            state_d = COUNT;
`else
            state_d = start ? COUNT : IDLE;
            if (start) begin
               cnt_d = '0;
               tmr_d = '0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   assign busy = (state_q == COUNT) || (state_q == DECIDE);
   assign done = done_q;
   assign winner = winner_q;
   assign winner_valid = valid_q;
   assign tie = tie_q;
   assign counts = cnt_q;
endmodule

// File: tb/tb_spike_window_decoder.sv
// tb_spike_window_decoder: directed window vectors plus reset and start-abuse sequences.
module tb_spike_window_decoder;
   logic clk = 1'b0, rst, en, start;
   logic [1:0] spike_in;
   logic busy, done, winner, winner_valid, tie;
   logic [7:0] counts;
   int checks = 0, failures = 0, cyc, lat, done_seen;
   typedef struct {
      string name;
      int c0, c1, stall, abuse, w, t, v, e0, e1, lat;
   } vec_t;
   vec_t tv[8];
   spike_window_decoder #(.NUM_OUT(2), .CNT_W(4), .WINDOW_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .spike_in(spike_in), .busy(busy),
      .done(done), .winner(winner), .winner_valid(winner_valid), .tie(tie), .counts(counts)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done && lat == 0) lat = cyc;
   endtask
   task automatic run(input vec_t x);
      lat = 0;
      start = 1'b1;
      en = 1'b1;
      spike_in = 2'b00;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      chk({x.name, " busy"}, busy, 1);
      for (int j = 0; j < 16; j++) begin
         if (x.stall != 0 && j == 8) begin
            for (int k = 0; k < x.stall; k++) begin
               en = 1'b0;
               spike_in = 2'b11;
               step();
            end
            en = 1'b1;
         end
         spike_in = {logic'(j < x.c1), logic'(j < x.c0)};
         start = logic'(x.abuse != 0 && j == 5);
         step();
      end
      spike_in = 2'b11;
      start = logic'(x.abuse != 0);
      while (lat == 0 && cyc < 60) begin
         step();
         start = 1'b0;
      end
      spike_in = 2'b00;
      chk({x.name, " latency"}, lat, x.lat);
      chk({x.name, " winner"}, winner, x.w);
      chk({x.name, " tie"}, tie, x.t);
      chk({x.name, " valid"}, winner_valid, x.v);
      chk({x.name, " cnt0"}, counts[3:0], x.e0);
      chk({x.name, " cnt1"}, counts[7:4], x.e1);
      step();
      chk({x.name, " done_1cyc"}, done, 0);
   endtask
   initial begin
      tv[0] = '{"basic", 10, 3, 0, 0, 0, 0, 1, 10, 3, 19};
      tv[1] = '{"tie", 5, 5, 0, 0, 0, 1, 1, 5, 5, 19};
      tv[2] = '{"silence", 0, 0, 0, 0, 0, 1, 0, 0, 0, 19};
      tv[3] = '{"sat_both", 16, 16, 0, 0, 0, 1, 1, 15, 15, 19};
      tv[4] = '{"sat_ch1", 14, 16, 0, 0, 1, 0, 1, 14, 15, 19};
      tv[5] = '{"stall", 10, 3, 7, 0, 0, 0, 1, 10, 3, 26};
      tv[6] = '{"abuse", 10, 3, 0, 1, 0, 0, 1, 10, 3, 19};
      tv[7] = '{"ch1_wins", 4, 9, 0, 0, 1, 0, 1, 4, 9, 19};
      rst = 1'b1;
      en = 1'b0;
      start = 1'b0;
      spike_in = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst done", done, 0);
      chk("rst busy", busy, 0);
      chk("rst winner", winner, 0);
      chk("rst valid", winner_valid, 0);
      chk("rst tie", tie, 0);
      chk("rst counts", counts, 0);
      rst = 1'b0;
      foreach (tv[i]) run(tv[i]);
      start = 1'b1;
      en = 1'b1;
      spike_in = 2'b11;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst counts", counts, 0);
      chk("midrst busy", busy, 0);
      chk("midrst winner", winner, 0);
      chk("midrst valid", winner_valid, 0);
      chk("midrst tie", tie, 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      chk("midrst no_done", done_seen, 0);
      chk("midrst idle", busy, 0);
      spike_in = 2'b00;
      run(tv[0]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spike_window_decoder.md
Name: spike_window_decoder

Overview:
- Output-decode stage directly downstream of spiking_network. Consumes the output-neuron spike lines (neuron_7, neuron_8, ...) and counts spikes per channel over a fixed observation window.
- At the end of each window it selects the winning class (highest spike count) and drives a compact result to the top-level outputs.
- Replaces the raw spike-to-pin wiring in the top level with a registered classification result.

Parameters:
- NUM_OUT, 2, number of output-neuron spike channels (2..8).
- CNT_W, 8, width of each per-channel spike counter; counters saturate.
- WINDOW_CYCLES, 256, number of enabled clock cycles in one observation window (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock-enable for window timer and counters; low freezes COUNT progress.
- start  input  1  request a new window; sampled only in IDLE (or DONE).
- spike_in  input  NUM_OUT  spike lines from spiking_network; bit i = output neuron i.
- busy  output  1  high in COUNT and DECIDE.
- done  output  1  one-cycle pulse when a new result is posted.
- winner  output  IDX_W  index of winning channel; IDX_W = max(1, $clog2(NUM_OUT)).
- winner_valid  output  1  1 if the max count > 0 in the last decided window.
- tie  output  1  1 if at least one other channel equals the max count.
- counts  output  NUM_OUT*CNT_W  live per-channel counters; channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async, any state): state=IDLE; all counters, window timer, winner, winner_valid, tie, busy, done = 0.
- States: IDLE -> COUNT -> DECIDE -> DONE -> IDLE.
- IDLE: start=1 clears all counters and the timer, then enters COUNT next cycle. Result outputs hold their previous values.
- COUNT:
  - Each cycle with en=1: for each i, if spike_in[i]=1 then counter i += 1, saturating at 2^CNT_W-1; timer += 1.
  - When the timer reaches WINDOW_CYCLES on an enabled cycle, go to DECIDE.
  - en=0: counters and timer hold; spikes are ignored.
  - start is ignored in COUNT.
- DECIDE: sequential argmax, one channel per cycle, NUM_OUT cycles total, in index order 0..NUM_OUT-1.
  - Running max is updated only on strictly greater, so on equal counts the lowest index wins.
  - Tie flag is set if any later channel equals the running max; it is cleared when a new strict max is found.
  - Unaffected by en.
- DONE (one cycle):
  - Register winner, tie, and winner_valid (winner_valid = max != 0). With all counts zero: winner=0, tie=1 if NUM_OUT>1, winner_valid=0.
  - Pulse done=1, then return to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE.
- Latency: with en held high, done asserts exactly WINDOW_CYCLES+NUM_OUT+1 cycles after the cycle start is sampled.
- Result outputs stay stable between done pulses. counts remain readable after DONE until the next accepted start.
- Timer width: $clog2(WINDOW_CYCLES+1). No combinational path from spike_in to any output.

Optional Feature:
- Macro: SPIKE_DECODE_AUTORESTART_EN.
- Defined: DONE goes directly to COUNT with counters and timer cleared, i.e. back-to-back windows without start. done still pulses every window; busy stays high except in the DONE cycle. start is ignored after the first window.
- Undefined: behaviour exactly as above; each window needs an explicit start.

Test Plan:
- Test parameters: NUM_OUT=2, CNT_W=4, WINDOW_CYCLES=16.
- Basic: start; spike_in[0] high 10 cycles, spike_in[1] high 3 cycles; en=1 -> done 19 cycles after start; winner=0, tie=0, winner_valid=1, counts={3,10}.
- Tie and silence:
  - Both channels spike 5 times -> winner=0, tie=1, winner_valid=1.
  - No spikes -> winner=0, winner_valid=0, tie=1.
- Saturation: spike_in=2'b11 for all 16 cycles, with channel 1 also high -> counts saturate at 15 each, tie=1, winner=0. Separately, ch1 high 16 cycles vs ch0 high 14 cycles -> counts {15,14}, winner=1.
- Enable stall: en low for 7 cycles mid-window while spikes toggle -> spikes during the stall are not counted; done arrives 7 cycles later (26 cycles after start).
- Reset and start abuse:
  - rst pulse during COUNT -> all outputs 0 immediately, state IDLE, no done.
  - start pulses during COUNT/DECIDE are ignored and do not extend the window.
- Autorestart build: single start -> done pulses every 19 cycles with fresh counts each window.
